// File: rtl/mem_loader.sv
// mem_loader: byte-stream program loader that fills core memory, then releases core reset.
// Ports:
//   clk_i, rstn_i (sync, active-low)
//   s_valid_i, s_data_i[7:0], s_ready_o   byte stream in (transfer when valid & ready)
//   mem_we_o, mem_waddr_o, mem_wdata_o    one-cycle word write into core memory
//   core_rstn_o                           active-low reset to the core, released on DONE
//   done_o, err_o, err_code_o[1:0]        status: 0 none, 1 size, 2 checksum, 3 timeout
// Frame: 4-byte LE word count N, N LE words, 1 checksum byte (sum of payload bytes mod 256).
// Optional: define LOADER_TIMEOUT_EN to abort after TIMEOUT_CYCLES idle cycles mid-frame.
module mem_loader #(
  parameter int XLEN           = 32,
  parameter int MEM_DEPTH      = 1024,
  parameter int ADDR_W         = $clog2(MEM_DEPTH),
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              s_valid_i,
  input  logic [7:0]        s_data_i,
  output logic              s_ready_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_waddr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  output logic              core_rstn_o,
  output logic              done_o,
  output logic              err_o,
  output logic [1:0]        err_code_o
);
  typedef enum logic [2:0] {HDR, DATA, CSUM, DONE, ERR} state_t;
  state_t state, state_d;
  logic [1:0]        byte_cnt;
  logic [23:0]       hbuf;
  logic [23:0]       wbuf;
  logic [31:0]       cnt;
  logic [31:0]       n_hdr;
  logic [ADDR_W-1:0] word_idx;
  logic [7:0]        csum;
  logic [1:0]        code_d;
  logic              acc;
  logic              last_word;
  logic              timeout;
  assign acc       = s_valid_i && s_ready_o;
  // full count as it becomes known on the 4th header byte
  assign n_hdr     = {s_data_i, hbuf};
  assign last_word = {{(32-ADDR_W){1'b0}}, word_idx} == cnt - 32'd1;
`ifdef LOADER_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  logic [IW-1:0] idle;
  logic          idle_en;
  // HDR only times out once a frame has actually started
  assign idle_en = state == DATA || state == CSUM || (state == HDR && byte_cnt != 2'd0);
  // the edge that completes TIMEOUT_CYCLES idle cycles moves to ERR
  assign timeout = idle_en && !acc && idle == IW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk_i)
    idle <= (!rstn_i || acc || !idle_en) ? '0 : idle + 1'b1;
`else
  assign timeout = TIMEOUT_CYCLES < 0;
`endif
  always_ff @(posedge clk_i)
    if (!rstn_i) state <= HDR;
    else         state <= state_d;
  always_comb begin
    state_d = state;
    code_d  = err_code_o;
    case (state)
      HDR:
        if (acc && byte_cnt == 2'd3) begin
          if (n_hdr > 32'(MEM_DEPTH)) begin
            state_d = ERR;
            code_d  = 2'd1;
          end else state_d = n_hdr == 32'd0 ? CSUM : DATA;
        end
      DATA:
        if (acc && byte_cnt == 2'd3 && last_word) state_d = CSUM;
      CSUM:
        if (acc) begin
          state_d = s_data_i == csum ? DONE : ERR;
          code_d  = s_data_i == csum ? 2'd0 : 2'd2;
        end
      default: state_d = state;
    endcase
    if (timeout) begin
      state_d = ERR;
      code_d  = 2'd3;
    end
  end
  always_comb begin
    s_ready_o   = state == HDR || state == DATA || state == CSUM;
    done_o      = state == DONE;
    err_o       = state == ERR;
    core_rstn_o = state == DONE;
  end
  always_ff @(posedge clk_i)
    if (!rstn_i) begin
      byte_cnt    <= '0;
      hbuf        <= '0;
      wbuf        <= '0;
      cnt         <= '0;
      word_idx    <= '0;
      csum        <= '0;
      mem_we_o    <= 1'b0;
      mem_waddr_o <= '0;
      mem_wdata_o <= '0;
      err_code_o  <= '0;
    end else begin
      mem_we_o   <= 1'b0;
      err_code_o <= code_d;
      if (acc) byte_cnt <= byte_cnt + 2'd1;
      if (acc && state == HDR) begin
        hbuf <= {s_data_i, hbuf[23:8]};
        if (byte_cnt == 2'd3) cnt <= n_hdr;
      end
      if (acc && state == DATA) begin
        csum <= csum + s_data_i;
        wbuf <= {s_data_i, wbuf[23:8]};
        if (byte_cnt == 2'd3) begin
          mem_we_o    <= 1'b1;
          mem_waddr_o <= word_idx;
          mem_wdata_o <= {s_data_i, wbuf};
          if (!last_word) word_idx <= word_idx + 1'b1;
        end
      end
    end
endmodule
